// File: rtl/ysyx_23060061_mem_pkg.sv
// Shared types and constants for the IFU/LSU data-memory arbiter.
package ysyx_23060061_mem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  // Requester ids; also the meaning of the priority bit (points at the favoured side).
  localparam logic REQ_IFU  = 1'b0;
  localparam logic REQ_LSU  = 1'b1;
  localparam logic PRIO_RST = REQ_LSU;

endpackage

// File: rtl/ysyx_23060061_rr_arb2.sv
// Two-way round-robin grant. Combinational grant from valids and the priority bit;
// the priority bit moves to the side not just served when a transaction retires.
module ysyx_23060061_rr_arb2
  import ysyx_23060061_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  input  logic done_i,
  input  logic done_id_i,
  output logic ifu_gnt_o,
  output logic lsu_gnt_o,
  output logic gnt_id_o
);

  logic prio_q, prio_d;

  // Priority update on retirement of a transaction.
  always_comb begin
    prio_d = prio_q;
    if (done_i) begin
      prio_d = ~done_id_i;
    end
  end

  // Priority register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PRIO_RST;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Winner selection: a lone requester always wins, a tie goes to the favoured side.
  always_comb begin
    gnt_id_o = REQ_IFU;
    if (ifu_valid_i && lsu_valid_i) begin
      gnt_id_o = prio_q;
    end else if (lsu_valid_i) begin
      gnt_id_o = REQ_LSU;
    end
    ifu_gnt_o = en_i && ifu_valid_i && (gnt_id_o == REQ_IFU);
    lsu_gnt_o = en_i && lsu_valid_i && (gnt_id_o == REQ_LSU);
  end

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Shares the data-memory port between IFU and LSU: one transaction in flight,
// captured at accept, issued to memory, response routed back to its owner.
module ysyx_23060061_mem_arbiter
  import ysyx_23060061_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                ifu_resp_ready,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  input  logic                lsu_resp_ready,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                mem_resp_ready
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic arb_en, ifu_gnt, lsu_gnt, gnt_id, done;

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_en        = (state_q == StIdle) && !rst;
  assign ifu_req_ready = ifu_gnt;
  assign lsu_req_ready = lsu_gnt;

  ysyx_23060061_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .en_i        (arb_en),
    .ifu_valid_i (ifu_req_valid),
    .lsu_valid_i (lsu_req_valid),
    .done_i      (done),
    .done_id_i   (owner_q),
    .ifu_gnt_o   (ifu_gnt),
    .lsu_gnt_o   (lsu_gnt),
    .gnt_id_o    (gnt_id)
  );

  // State and captured-transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= REQ_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state: capture on grant, advance on each handshake.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lsu_gnt) begin
          owner_d = REQ_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          state_d = StIssue;
        end else if (ifu_gnt) begin
          owner_d = REQ_IFU;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_resp_valid) begin
          rdata_d = mem_resp_data;
          state_d = StResp;
        end
      end
      StResp: begin
        if ((owner_q == REQ_LSU) ? lsu_resp_ready : ifu_resp_ready) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: everything idles at zero outside its own state and while reset is held.
  always_comb begin
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_wen    = 1'b0;
    mem_req_wdata  = '0;
    mem_req_wmask  = '0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_data  = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data  = '0;
    if (!rst) begin
      unique case (state_q)
        StIssue: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = addr_q;
          mem_req_wen   = wen_q;
          mem_req_wdata = wdata_q;
          mem_req_wmask = wmask_q;
        end
        StWait: mem_resp_ready = 1'b1;
        StResp: begin
          if (owner_q == REQ_LSU) begin
            lsu_resp_valid = 1'b1;
            lsu_resp_data  = rdata_q;
          end else begin
            ifu_resp_valid = 1'b1;
            ifu_resp_data  = rdata_q;
          end
        end
        default: ;
      endcase
    end
  end

  // gnt_id is folded into the one-hot grants; kept for visibility.
  logic unused_gnt_id;
  assign unused_gnt_id = gnt_id;

endmodule
